// File: rtl/program_loader.sv
// Framed byte-stream loader: buffers a header-prefixed image of up to MEM_DEPTH bytes,
// then holds the CPU in reset and streams the whole zero-filled image through its load port.
module program_loader #(
    parameter int MEM_DEPTH  = 32,
    parameter int ADDR_W     = 5,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cpu_reset,
    output logic       cpu_load,
    output logic [7:0] cpu_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [5:0]        MAX_N     = 6'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_CRST   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         image_r [MEM_DEPTH];
    logic [5:0]         len_r;
    logic [5:0]         wptr_r;
    logic [5:0]         k_r;
    logic [RST_W-1:0]   rst_cnt_r;
    logic [IDLE_W-1:0]  idle_cnt_r;

    logic               xfer_s;
    logic               hdr_ok_s;
    logic               hdr_take_s;
    logic               byte_take_s;
    logic               timeout_s;
    logic               in_ready_s;
    logic               cpu_reset_s;
    logic               cpu_load_s;
    logic [7:0]         cpu_data_s;
    logic               busy_s;
    logic               done_s;
    logic               error_s;

    // The registered in_ready reflects the current state, so it gates the handshake directly.
    assign xfer_s      = in_valid & in_ready;
    assign hdr_ok_s    = (in_data[5:0] != 6'd0) && (in_data[5:0] <= MAX_N);
    assign hdr_take_s  = xfer_s && (state_r == ST_IDLE) && hdr_ok_s;
    assign byte_take_s = xfer_s && (state_r == ST_RECV);
    assign timeout_s   = (state_r == ST_RECV) && !xfer_s && (idle_cnt_r == IDLE_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hdr_take_s) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (byte_take_s && (wptr_r == (len_r - 6'd1))) begin
                    state_s = ST_CRST;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_CRST: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_CRST;
                end
            end
            ST_STREAM: begin
                if (k_r == MAX_N) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so outputs can be registered.
    always_comb begin
        in_ready_s  = 1'b0;
        cpu_reset_s = 1'b0;
        cpu_load_s  = 1'b0;
        cpu_data_s  = 8'h00;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        error_s     = 1'b0;
        case (state_s)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_RECV: begin
                in_ready_s = 1'b1;
            end
            ST_CRST: begin
                cpu_reset_s = 1'b1;
            end
            ST_STREAM: begin
                cpu_load_s = 1'b1;
                cpu_data_s = image_r[k_r[ADDR_W-1:0]];
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
        if (((state_r == ST_IDLE) && xfer_s && !hdr_ok_s) || timeout_s) begin
            error_s = 1'b1;
        end else begin
            error_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready  <= 1'b1;
            cpu_reset <= 1'b0;
            cpu_load  <= 1'b0;
            cpu_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            in_ready  <= in_ready_s;
            cpu_reset <= cpu_reset_s;
            cpu_load  <= cpu_load_s;
            cpu_data  <= cpu_data_s;
            busy      <= busy_s;
            done      <= done_s;
            error     <= error_s;
        end
    end

    // Frame length, write pointer, stream index and the reset/idle cycle counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_r      <= 6'd0;
            wptr_r     <= 6'd0;
            k_r        <= 6'd0;
            rst_cnt_r  <= '0;
            idle_cnt_r <= '0;
        end else begin
            if (hdr_take_s) begin
                len_r  <= in_data[5:0];
                wptr_r <= 6'd0;
            end else if (byte_take_s) begin
                wptr_r <= wptr_r + 6'd1;
            end else begin
                wptr_r <= wptr_r;
            end
            // k runs ahead by one: the edge entering STREAM already presents byte 0.
            if (state_s == ST_STREAM) begin
                k_r <= k_r + 6'd1;
            end else begin
                k_r <= 6'd0;
            end
            if (state_r == ST_CRST) begin
                rst_cnt_r <= rst_cnt_r + RST_W'(1);
            end else begin
                rst_cnt_r <= '0;
            end
            if ((state_r == ST_RECV) && !xfer_s) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

    // Image buffer: cleared on an accepted header so unused addresses stream as zero (HLT).
    always_ff @(posedge clock) begin
        if (!reset && hdr_take_s) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                image_r[i] <= 8'h00;
            end
        end else if (!reset && byte_take_s) begin
            image_r[wptr_r[ADDR_W-1:0]] <= in_data;
        end else begin
            image_r <= image_r;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: framing, zero-fill streaming,
// header rejection, timeout, throttled source and reset during streaming.
module tb_program_loader;

    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cpu_reset;
    logic       cpu_load;
    logic [7:0] cpu_data;
    logic       busy;
    logic       done;
    logic       error;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] img [32];

    program_loader #(
        .MEM_DEPTH  (32),
        .ADDR_W     (5),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cpu_reset (cpu_reset),
        .cpu_load  (cpu_load),
        .cpu_data  (cpu_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte until it transfers (bounded), then drop in_valid.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (in_ready === 1'b1) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("byte_accepted", {7'd0, acc}, 8'd1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int n);
        send_byte(hdr);
        for (int i = 0; i < n; i++) send_byte(img[i]);
    endtask

    // Called right after the edge that took the last payload byte.
    task automatic expect_load(input int n);
        logic [7:0] exp;
        for (int r = 0; r < RST_CYCLES; r++) begin
            chk("crst_cpu_reset", {7'd0, cpu_reset}, 8'd1);
            chk("crst_cpu_load", {7'd0, cpu_load}, 8'd0);
            chk("crst_in_ready", {7'd0, in_ready}, 8'd0);
            tick();
        end
        for (int k = 0; k < 32; k++) begin
            exp = (k < n) ? img[k] : 8'h00;
            chk("stream_cpu_load", {7'd0, cpu_load}, 8'd1);
            chk("stream_cpu_data", cpu_data, exp);
            chk("stream_cpu_reset", {7'd0, cpu_reset}, 8'd0);
            chk("stream_in_ready", {7'd0, in_ready}, 8'd0);
            tick();
        end
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("done_cpu_load", {7'd0, cpu_load}, 8'd0);
        chk("done_cpu_data", cpu_data, 8'h00);
        chk("done_no_error", {7'd0, error}, 8'd0);
        chk("done_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("after_done", {7'd0, done}, 8'd0);
        chk("after_busy", {7'd0, busy}, 8'd0);
        chk("after_in_ready", {7'd0, in_ready}, 8'd1);
    endtask

    task automatic bad_header(input logic [7:0] hdr);
        send_byte(hdr);
        chk("bad_hdr_error", {7'd0, error}, 8'd1);
        chk("bad_hdr_busy", {7'd0, busy}, 8'd0);
        chk("bad_hdr_in_ready", {7'd0, in_ready}, 8'd1);
        chk("bad_hdr_cpu_reset", {7'd0, cpu_reset}, 8'd0);
        chk("bad_hdr_cpu_load", {7'd0, cpu_load}, 8'd0);
        tick();
        chk("bad_hdr_error_drop", {7'd0, error}, 8'd0);
        chk("bad_hdr_still_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 32; i++) img[i] = 8'((i * 37 + 11) & 255);
        img[0] = 8'hBB; img[1] = 8'h7C; img[2] = 8'h9B; img[3] = 8'h20;
        img[26] = 8'h01; img[27] = 8'hAA; img[28] = 8'hFF; img[29] = 8'h00;

        // Reset values
        tick();
        tick();
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_cpu_reset", {7'd0, cpu_reset}, 8'd0);
        chk("rst_cpu_load", {7'd0, cpu_load}, 8'd0);
        chk("rst_cpu_data", cpu_data, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_error", {7'd0, error}, 8'd0);
        reset = 1'b0;
        tick();

        // Bad headers: N=0, N=33, N=63, and N=0 with ignored top bits set
        bad_header(8'h00);
        bad_header(8'h21);
        bad_header(8'h3F);
        bad_header(8'h40);

        // Full 32-byte program
        send_frame(8'h20, 32);
        chk("full_busy_after_last", {7'd0, busy}, 8'd1);
        expect_load(32);

        // Short frame, zero-filled tail
        img[0] = 8'hBB; img[1] = 8'h7C; img[2] = 8'h00;
        send_frame(8'h03, 3);
        expect_load(3);

        // Timeout after two of four bytes
        send_byte(8'h04);
        send_byte(8'h12);
        send_byte(8'h34);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_not_yet_error", {7'd0, error}, 8'd0);
        chk("to_not_yet_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("to_error", {7'd0, error}, 8'd1);
        chk("to_busy", {7'd0, busy}, 8'd0);
        chk("to_in_ready", {7'd0, in_ready}, 8'd1);
        chk("to_cpu_reset", {7'd0, cpu_reset}, 8'd0);
        chk("to_cpu_load", {7'd0, cpu_load}, 8'd0);
        tick();
        chk("to_error_drop", {7'd0, error}, 8'd0);

        // Throttled source, then a byte held during the load
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44; img[4] = 8'h55;
        send_byte(8'h05);
        for (int i = 0; i < 5; i++) begin
            tick();
            send_byte(img[i]);
        end
        in_data  = 8'h40;
        in_valid = 1'b1;
        expect_load(5);
        chk("held_not_taken_error", {7'd0, error}, 8'd0);
        tick();
        chk("held_taken_error", {7'd0, error}, 8'd1);
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        chk("held_error_drop", {7'd0, error}, 8'd0);

        // Reset in the middle of streaming (k=10)
        for (int i = 0; i < 32; i++) img[i] = 8'((i * 37 + 11) & 255);
        send_frame(8'h20, 32);
        for (int i = 0; i < RST_CYCLES + 10; i++) tick();
        chk("mid_cpu_load", {7'd0, cpu_load}, 8'd1);
        chk("mid_cpu_data", cpu_data, img[10]);
        reset = 1'b1;
        tick();
        chk("mid_rst_cpu_load", {7'd0, cpu_load}, 8'd0);
        chk("mid_rst_cpu_reset", {7'd0, cpu_reset}, 8'd0);
        chk("mid_rst_cpu_data", cpu_data, 8'h00);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
        tick();
        reset = 1'b0;
        chk("mid_rst2_cpu_load", {7'd0, cpu_load}, 8'd0);

        // New frame loads correctly after the interrupted one
        img[0] = 8'hC3; img[1] = 8'h5A;
        send_frame(8'hC2, 2);
        expect_load(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
